// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic 2:1 AXI-Stream arbiter: port 0 carries the data path and port 1 the control path.
// A grant is held until the packet's tlast beat is accepted. The merged output is fully registered.
module axis_pkt_arbiter #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned PRIO_MODE            = 0
) (
  input  logic                                clk,
  input  logic                                areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
  input  logic                                s0_axis_tvalid,
  input  logic                                s0_axis_tlast,
  output logic                                s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
  input  logic                                s1_axis_tvalid,
  input  logic                                s1_axis_tlast,
  output logic                                s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [31:0]                         pkt_cnt_0,
  output logic [31:0]                         pkt_cnt_1
);

  localparam int unsigned DATA_W = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned USER_W = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCK0 = 2'd1;
  localparam logic [1:0] S_LOCK1 = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } beat_t;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_last_served;
  beat_t            r_m_beat;
  logic             r_m_tvalid;
  logic [CNT_W-1:0] r_pkt_cnt_0;
  logic [CNT_W-1:0] r_pkt_cnt_1;

  logic  w_out_free;
  logic  w_sel1;
  logic  w_gnt0;
  logic  w_gnt1;
  logic  w_rdy0;
  logic  w_rdy1;
  logic  w_acc0;
  logic  w_acc1;
  logic  w_done0;
  logic  w_done1;
  beat_t w_beat0;
  beat_t w_beat1;

  assign w_beat0 = {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast};
  assign w_beat1 = {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast};

  assign w_out_free = ~r_m_tvalid | m_axis_tready;

  // Packet-boundary selection; last_served breaks ties in round-robin mode
  always_comb begin
    w_sel1 = s1_axis_tvalid;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      w_sel1 = (PRIO_MODE != 0) ? 1'b1 : ~r_last_served;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, ready and next-state decode
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_gnt0 = (s0_axis_tvalid | s1_axis_tvalid) & ~w_sel1;
        w_gnt1 = w_sel1;
      end
      S_LOCK0: w_gnt0 = 1'b1;
      S_LOCK1: w_gnt1 = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase

    w_rdy0  = w_gnt0 & w_out_free & ~areset;
    w_rdy1  = w_gnt1 & w_out_free & ~areset;
    w_acc0  = w_rdy0 & s0_axis_tvalid;
    w_acc1  = w_rdy1 & s1_axis_tvalid;
    w_done0 = w_acc0 & s0_axis_tlast;
    w_done1 = w_acc1 & s1_axis_tlast;

    if (w_acc0) begin
      w_state_nxt = s0_axis_tlast ? S_IDLE : S_LOCK0;
    end else if (w_acc1) begin
      w_state_nxt = s1_axis_tlast ? S_IDLE : S_LOCK1;
    end
  end

  // Single output stage: load on accept, drain when downstream takes the beat
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_m_beat   <= '0;
      r_m_tvalid <= 1'b0;
    end else if (w_acc0 || w_acc1) begin
      r_m_beat   <= w_acc1 ? w_beat1 : w_beat0;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Completed-packet bookkeeping; only one port can finish per cycle
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_last_served <= 1'b1;
      r_pkt_cnt_0   <= '0;
      r_pkt_cnt_1   <= '0;
    end else begin
      if (w_done0) begin
        r_last_served <= 1'b0;
        r_pkt_cnt_0   <= r_pkt_cnt_0 + CNT_W'(1);
      end
      if (w_done1) begin
        r_last_served <= 1'b1;
        r_pkt_cnt_1   <= r_pkt_cnt_1 + CNT_W'(1);
      end
    end
  end

  assign s0_axis_tready = w_rdy0;
  assign s1_axis_tready = w_rdy1;
  assign m_axis_tdata   = r_m_beat.tdata;
  assign m_axis_tkeep   = r_m_beat.tkeep;
  assign m_axis_tuser   = r_m_beat.tuser;
  assign m_axis_tlast   = r_m_beat.tlast;
  assign m_axis_tvalid  = r_m_tvalid;
  assign pkt_cnt_0      = r_pkt_cnt_0;
  assign pkt_cnt_1      = r_pkt_cnt_1;

endmodule
